// File: rtl/vote_pkg.sv
// Shared definitions for the voting tally stage: candidate indices, FSM states and reject codes.
package vote_pkg;

    localparam int NUM_CAND = 5;

    localparam logic [2:0] CAND_A = 3'd0;
    localparam logic [2:0] CAND_B = 3'd1;
    localparam logic [2:0] CAND_C = 3'd2;
    localparam logic [2:0] CAND_D = 3'd3;
    localparam logic [2:0] CAND_E = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_CLOSED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REJ_OK    = 2'd0,
        REJ_CAND  = 2'd1,
        REJ_DUP   = 2'd2,
        REJ_RANGE = 2'd3
    } rej_t;

endpackage

// File: rtl/voter_registry.sv
// One bit per voter ID recording "already voted" this session. Writes are posted one cycle
// and forwarded to the test port so a back-to-back ballot from the same ID sees the mark.
module voter_registry #(
    parameter int NUM_VOTERS = 16,
    parameter int VOTER_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [VOTER_W-1:0] test_id,
    output logic               test_hit,
    input  logic               set_en,
    input  logic [VOTER_W-1:0] set_id
);

    logic [NUM_VOTERS-1:0] bits_q, bits_d;
    logic [NUM_VOTERS-1:0] test_oh, pend_oh;
    logic                  pend_q, pend_d;
    logic [VOTER_W-1:0]    pend_id_q, pend_id_d;

    generate
        for (genvar gi = 0; gi < NUM_VOTERS; gi++) begin : g_dec
            assign test_oh[gi] = (test_id == VOTER_W'(gi));
            assign pend_oh[gi] = pend_q && (pend_id_q == VOTER_W'(gi));
        end
    endgenerate

    // Pending write is folded into the lookup, so the posted write costs no bubble.
    assign test_hit = |(test_oh & (bits_q | pend_oh));

    always_comb begin
        bits_d    = bits_q | pend_oh;
        pend_d    = set_en;
        pend_id_d = set_id;
        if (clear) begin
            bits_d = '0;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q    <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= '0;
        end else begin
            bits_q    <= bits_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
        end
    end

endmodule

// File: rtl/vote_tally.sv
// Session FSM, ballot handshake and saturating per-candidate tallies feeding the max-finder.
module vote_tally
    import vote_pkg::*;
#(
    parameter int NUM_VOTERS = 16,
    parameter int VOTER_W    = 4,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sess_open,
    input  logic               sess_close,
    input  logic               sess_clear,
    input  logic               vote_valid,
    input  logic [2:0]         vote_cand,
    input  logic [VOTER_W-1:0] voter_id,
    output logic               vote_ready,
    output logic               vote_ack,
    output logic [1:0]         vote_rej,
    output logic [CNT_W-1:0]   count_a,
    output logic [CNT_W-1:0]   count_b,
    output logic [CNT_W-1:0]   count_c,
    output logic [CNT_W-1:0]   count_d,
    output logic [CNT_W-1:0]   count_e,
    output logic [CNT_W-1:0]   total_votes,
    output logic               results_valid
);

    localparam logic [VOTER_W:0] NV_LIM = (VOTER_W + 1)'(NUM_VOTERS);

    state_t state_q, state_d;
    rej_t   rej_code;
    rej_t   rej_q, rej_d;
    logic   ack_q, ack_d;
    logic   take, accept, dup_hit, id_out;

    logic [CNT_W-1:0] total_q, total_d;
    logic [NUM_CAND-1:0][CNT_W-1:0] cnt_vec;

    always_comb begin
        state_d = state_q;
        if (sess_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (sess_open)  state_d = ST_OPEN;
                ST_OPEN:  if (sess_close) state_d = ST_CLOSED;
                default:  state_d = state_q;
            endcase
        end
    end

    assign vote_ready    = (state_q == ST_OPEN) && !sess_close && !sess_clear;
    assign results_valid = (state_q == ST_CLOSED);
    assign take          = vote_valid && vote_ready;
    assign id_out        = ({1'b0, voter_id} >= NV_LIM);

    voter_registry #(
        .NUM_VOTERS (NUM_VOTERS),
        .VOTER_W    (VOTER_W)
    ) u_registry (
        .clk      (clk),
        .rst      (rst),
        .clear    (sess_clear),
        .test_id  (voter_id),
        .test_hit (dup_hit),
        .set_en   (accept),
        .set_id   (voter_id)
    );

    always_comb begin
        rej_code = REJ_OK;
        if (id_out) begin
            rej_code = REJ_RANGE;
        end else if (vote_cand > CAND_E) begin
            rej_code = REJ_CAND;
        end else if (dup_hit) begin
            rej_code = REJ_DUP;
        end
    end

    assign accept = take && (rej_code == REJ_OK);

    always_comb begin
        ack_d = take;
        rej_d = take ? rej_code : REJ_OK;
    end

    generate
        for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (sess_clear) begin
                    cnt_d = '0;
                end else if (accept && (vote_cand == 3'(gi)) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) cnt_q <= '0;
                else      cnt_q <= cnt_d;
            end

            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    always_comb begin
        total_d = total_q;
        if (sess_clear) begin
            total_d = '0;
        end else if (accept && (total_q != '1)) begin
            total_d = total_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            total_q <= '0;
            ack_q   <= 1'b0;
            rej_q   <= REJ_OK;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
        end
    end

    assign vote_ack    = ack_q;
    assign vote_rej    = rej_q;
    assign total_votes = total_q;
    assign count_a     = cnt_vec[0];
    assign count_b     = cnt_vec[1];
    assign count_c     = cnt_vec[2];
    assign count_d     = cnt_vec[3];
    assign count_e     = cnt_vec[4];

endmodule

// File: tb/tb_vote_tally.sv
// Scoreboard bench: two tallies (32-bit counters / 5-bit IDs, and 2-bit counters / 4-bit IDs)
// share stimulus; a session-level model predicts each ack, monitors pop and compare.
module tb_vote_tally;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sess_open = 1'b0, sess_close = 1'b0, sess_clear = 1'b0;
    logic        vote_valid = 1'b0;
    logic [2:0]  vote_cand = 3'd0;
    logic [4:0]  voter_id = 5'd0;

    logic        ready0, ack0, rv0, ready1, ack1, rv1;
    logic [1:0]  rej0, rej1;
    logic [31:0] a0, b0, c0, d0, e0, t0;
    logic [1:0]  a1, b1, c1, d1, e1, t1;

    always #5 clk = ~clk;

    vote_tally #(.NUM_VOTERS(16), .VOTER_W(5), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .sess_open(sess_open), .sess_close(sess_close),
        .sess_clear(sess_clear), .vote_valid(vote_valid), .vote_cand(vote_cand),
        .voter_id(voter_id), .vote_ready(ready0), .vote_ack(ack0), .vote_rej(rej0),
        .count_a(a0), .count_b(b0), .count_c(c0), .count_d(d0), .count_e(e0),
        .total_votes(t0), .results_valid(rv0));

    vote_tally #(.NUM_VOTERS(16), .VOTER_W(4), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .sess_open(sess_open), .sess_close(sess_close),
        .sess_clear(sess_clear), .vote_valid(vote_valid), .vote_cand(vote_cand),
        .voter_id(voter_id[3:0]), .vote_ready(ready1), .vote_ack(ack1), .vote_rej(rej1),
        .count_a(a1), .count_b(b1), .count_c(c1), .count_d(d1), .count_e(e1),
        .total_votes(t1), .results_valid(rv1));

    typedef struct {
        int     rej;
        int     cand;
        longint cnt;
        longint tot;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;

    // Session model: 0=idle 1=open 2=closed
    int     m_state = 0;
    longint m_cnt[2][5];
    longint m_tot[2];
    bit     m_voted[2][16];
    longint m_max[2] = '{64'd4294967295, 64'd3};

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic longint pick(input int c, input longint a, input longint b,
                                    input longint cc, input longint d, input longint e);
        case (c)
            0: return a;
            1: return b;
            2: return cc;
            3: return d;
            default: return e;
        endcase
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_tot[d] = 0;
            for (int c = 0; c < 5; c++) m_cnt[d][c] = 0;
            for (int v = 0; v < 16; v++) m_voted[d][v] = 1'b0;
        end
    endtask

    task automatic model_take(input int d, input int id, input int cand);
        exp_t e;
        int   idm;
        idm = (d == 0) ? id : (id % 16);
        e.cand = cand;
        if (idm >= 16) begin
            e.rej = 3;
        end else if (cand > 4) begin
            e.rej = 1;
        end else if (m_voted[d][idm]) begin
            e.rej = 2;
        end else begin
            e.rej = 0;
            m_voted[d][idm] = 1'b1;
            if (m_cnt[d][cand] < m_max[d]) m_cnt[d][cand]++;
            if (m_tot[d] < m_max[d]) m_tot[d]++;
        end
        e.cnt = (cand < 5) ? m_cnt[d][cand] : 0;
        e.tot = m_tot[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && ack0) begin
            if (q0.size() == 0) begin
                chk("ack0_unexpected", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("rej0", rej0, e.rej);
                chk("tot0_at_ack", t0, e.tot);
                if (e.cand < 5) chk("cnt0_at_ack", pick(e.cand, a0, b0, c0, d0, e0), e.cnt);
                $display("dut0 ack rej=%0d cand=%0d total=%0d", rej0, e.cand, t0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && ack1) begin
            if (q1.size() == 0) begin
                chk("ack1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("rej1", rej1, e.rej);
                chk("tot1_at_ack", t1, e.tot);
                if (e.cand < 5) chk("cnt1_at_ack", pick(e.cand, a1, b1, c1, d1, e1), e.cnt);
                $display("dut1 ack rej=%0d cand=%0d total=%0d", rej1, e.cand, t1);
            end
        end
    end

    task automatic check_all(input string tag);
        chk({tag, "_ready0"}, ready0, m_state == 1);
        chk({tag, "_ready1"}, ready1, m_state == 1);
        chk({tag, "_rv0"}, rv0, m_state == 2);
        chk({tag, "_rv1"}, rv1, m_state == 2);
        chk({tag, "_a0"}, a0, m_cnt[0][0]);
        chk({tag, "_b0"}, b0, m_cnt[0][1]);
        chk({tag, "_c0"}, c0, m_cnt[0][2]);
        chk({tag, "_d0"}, d0, m_cnt[0][3]);
        chk({tag, "_e0"}, e0, m_cnt[0][4]);
        chk({tag, "_t0"}, t0, m_tot[0]);
        chk({tag, "_a1"}, a1, m_cnt[1][0]);
        chk({tag, "_b1"}, b1, m_cnt[1][1]);
        chk({tag, "_c1"}, c1, m_cnt[1][2]);
        chk({tag, "_d1"}, d1, m_cnt[1][3]);
        chk({tag, "_e1"}, e1, m_cnt[1][4]);
        chk({tag, "_t1"}, t1, m_tot[1]);
        $display("check %s state=%0d t0=%0d t1=%0d", tag, m_state, t0, t1);
    endtask

    task automatic cast(input int id, input int cand);
        logic [4:0] idv;
        logic [2:0] cv;
        idv = id[4:0];
        cv  = cand[2:0];
        vote_valid = 1'b1;
        voter_id   = idv;
        vote_cand  = cv;
        #1;
        chk("ready0_cast", ready0, m_state == 1);
        chk("ready1_cast", ready1, m_state == 1);
        @(posedge clk);
        if (m_state == 1) begin
            model_take(0, id, cand);
            model_take(1, id, cand);
        end
        #1;
    endtask

    task automatic idle();
        vote_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit o, input bit c, input bit cl);
        vote_valid = 1'b0;
        sess_open  = o;
        sess_close = c;
        sess_clear = cl;
        @(posedge clk);
        if (cl) begin
            m_state = 0;
            model_clear();
        end else if (c && m_state == 1) begin
            m_state = 2;
        end else if (o && m_state == 0) begin
            m_state = 1;
        end
        #1;
        sess_open  = 1'b0;
        sess_close = 1'b0;
        sess_clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_rej0"}, rej0, 0);
        chk({tag, "_rej1"}, rej1, 0);
        check_all(tag);
    endtask

    initial begin
        model_clear();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Ballots while IDLE are not taken
        cast(7, 0);
        cast(7, 0);
        idle();
        pulse(0, 1, 0);
        check_all("idle_vote");

        pulse(1, 0, 0);
        cast(0, 1);
        cast(1, 3);
        cast(2, 1);
        idle();
        check_all("basic");

        cast(5, 0);
        cast(5, 2);
        idle();
        check_all("dup");

        cast(3, 6);
        cast(20, 0);
        idle();
        check_all("badcand_range");

        pulse(0, 1, 0);
        check_all("closed");
        cast(7, 0);
        cast(8, 2);
        idle();
        pulse(1, 0, 0);
        check_all("closed_frozen");

        pulse(0, 0, 1);
        pulse(1, 0, 0);
        for (int i = 0; i < 4; i++) cast(i, 4);
        idle();
        check_all("saturate");

        cast(8, 1);
        idle();
        pulse(0, 1, 1);
        check_all("close_clear");
        pulse(1, 0, 0);
        cast(8, 1);
        idle();
        check_all("after_clear");

        cast(9, 2);
        cast(10, 2);
        rst = 1'b0;
        q0.delete();
        q1.delete();
        m_state = 0;
        model_clear();
        #1;
        check_reset_outputs("async_rst");
        vote_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int s = 0; s < 3; s++) begin
            pulse(1, 0, 0);
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    int cand;
                    cand = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
                    cast($urandom_range(0, 19), cand);
                end else begin
                    idle();
                end
            end
            idle();
            pulse(0, 1, 0);
            check_all("rand_closed");
            pulse(0, 0, 1);
            check_all("rand_cleared");
        end

        idle();
        idle();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
